// File: rtl/bp_dma_bank_arbiter.sv
// -----------------------------------------------------------------------------
// bp_dma_bank_arbiter
//
// Shares one off-chip DMA link among num_banks_p L2 bank DMA ports.
//   - Packets: round-robin arbitration, one grant per packet handshake.
//   - Write data: after a write packet is granted, burst_len_p beats are routed
//     from the granted bank (wbank) to DRAM before the next packet is accepted.
//   - Read data: returned to banks in issue order; an order FIFO records the
//     bank id of every granted read packet, and each burst_len_p-beat burst
//     goes to the bank at the FIFO head. This path runs concurrently with the
//     packet/write FSM.
//
// Handshake rule for every port pair: a transfer happens on a cycle where both
// valid and ready are high. Valid never depends on ready; ready may depend on
// valid.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   bank_pkt_i/_v_i/_ready_and_o        per-bank DMA packet (bit msb = write)
//   bank_wdata_i/_v_i/_ready_and_o      per-bank write data
//   bank_rdata_o/_v_o, bank_rdata_ready_and_i  read data to banks (data
//                                       broadcast, valid one-hot)
//   dma_pkt_o/_v_o/_ready_and_i         packet to DRAM
//   dma_wdata_o/_v_o/_ready_and_i       write data to DRAM
//   dma_rdata_i/_v_i/_ready_and_o       read data from DRAM
//   perf_grant_cnt_o, perf_rd_full_stall_o  only with BP_DMA_ARB_PERF_EN
//
// Optional feature macro: BP_DMA_ARB_PERF_EN adds saturating performance
// counters (per-bank grant counts, read-blocked-by-full-FIFO cycles).
// -----------------------------------------------------------------------------
module bp_dma_bank_arbiter #(
  parameter int num_banks_p   = 2,
  parameter int pkt_width_p   = 40,
  parameter int data_width_p  = 64,
  parameter int burst_len_p   = 8,
  parameter int rd_fifo_els_p = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_banks_p*pkt_width_p-1:0]  bank_pkt_i,
  input  logic [num_banks_p-1:0]              bank_pkt_v_i,
  output logic [num_banks_p-1:0]              bank_pkt_ready_and_o,
  input  logic [num_banks_p*data_width_p-1:0] bank_wdata_i,
  input  logic [num_banks_p-1:0]              bank_wdata_v_i,
  output logic [num_banks_p-1:0]              bank_wdata_ready_and_o,
  output logic [num_banks_p*data_width_p-1:0] bank_rdata_o,
  output logic [num_banks_p-1:0]              bank_rdata_v_o,
  input  logic [num_banks_p-1:0]              bank_rdata_ready_and_i,
  output logic [pkt_width_p-1:0]              dma_pkt_o,
  output logic                                dma_pkt_v_o,
  input  logic                                dma_pkt_ready_and_i,
  output logic [data_width_p-1:0]             dma_wdata_o,
  output logic                                dma_wdata_v_o,
  input  logic                                dma_wdata_ready_and_i,
  input  logic [data_width_p-1:0]             dma_rdata_i,
  input  logic                                dma_rdata_v_i,
  output logic                                dma_rdata_ready_and_o
`ifdef BP_DMA_ARB_PERF_EN
  ,
  output logic [num_banks_p*32-1:0]           perf_grant_cnt_o,
  output logic [31:0]                         perf_rd_full_stall_o
`endif
);

  localparam int id_w_lp  = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
  localparam int cnt_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int ptr_w_lp = $clog2(rd_fifo_els_p);
  localparam int occ_w_lp = $clog2(rd_fifo_els_p + 1);

  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(burst_len_p - 1);
  localparam logic [id_w_lp-1:0]  last_bank_lp = id_w_lp'(num_banks_p - 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp  = ptr_w_lp'(rd_fifo_els_p - 1);
  localparam logic [occ_w_lp-1:0] fifo_els_lp  = occ_w_lp'(rd_fifo_els_p);

  typedef enum logic {S_PKT, S_WDATA} state_e;

  state_e               state_q, state_d;
  logic [id_w_lp-1:0]   rr_q, rr_d;
  logic [id_w_lp-1:0]   wbank_q, wbank_d;
  logic [cnt_w_lp-1:0]  wcnt_q, wcnt_d;
  logic [cnt_w_lp-1:0]  rcnt_q;
  logic [id_w_lp-1:0]   fifo_mem_q [rd_fifo_els_p];
  logic [ptr_w_lp-1:0]  wptr_q, rptr_q;
  logic [occ_w_lp-1:0]  occ_q;

  logic                   fifo_full, fifo_empty;
  logic [num_banks_p-1:0] is_write, eligible;
  logic                   any_elig;
  logic [id_w_lp-1:0]     winner;
  logic [pkt_width_p-1:0] win_pkt;
  logic                   win_is_write;
  logic [id_w_lp-1:0]     head;
  logic                   in_pkt, in_wdata;
  logic                   pkt_hs, wd_hs, rd_hs, push, pop;

  // Fullness is taken from the registered occupancy, so a pop in the same
  // cycle does not open the door for a new read grant until the next cycle.
  assign fifo_full  = (occ_q == fifo_els_lp);
  assign fifo_empty = (occ_q == '0);

  always_comb begin
    is_write = '0;
    eligible = '0;
    for (int i = 0; i < num_banks_p; i++) begin
      is_write[i] = bank_pkt_i[i*pkt_width_p + pkt_width_p - 1];
      eligible[i] = bank_pkt_v_i[i] & (is_write[i] | ~fifo_full);
    end
  end

  // Round-robin search: scan offsets from the far end down so the eligible
  // bank closest to (at or after) rr_q is the last one written and wins.
  always_comb begin
    int idx;
    idx      = 0;
    any_elig = 1'b0;
    winner   = '0;
    for (int k = num_banks_p - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= num_banks_p) idx = idx - num_banks_p;
      if (eligible[idx]) begin
        any_elig = 1'b1;
        winner   = id_w_lp'(idx);
      end
    end
  end

  assign win_pkt      = bank_pkt_i[winner*pkt_width_p +: pkt_width_p];
  assign win_is_write = win_pkt[pkt_width_p-1];
  assign head         = fifo_mem_q[rptr_q];

  // Outputs are gated by reset_n_i so every valid/ready drops the moment
  // reset is asserted, even though some of them are combinational paths.
  assign in_pkt   = reset_n_i & (state_q == S_PKT);
  assign in_wdata = reset_n_i & (state_q == S_WDATA);

  always_comb begin
    bank_pkt_ready_and_o   = '0;
    bank_wdata_ready_and_o = '0;
    bank_rdata_v_o         = '0;
    dma_pkt_o              = win_pkt;
    dma_pkt_v_o            = in_pkt & any_elig;
    dma_wdata_o            = bank_wdata_i[wbank_q*data_width_p +: data_width_p];
    dma_wdata_v_o          = in_wdata & bank_wdata_v_i[wbank_q];
    bank_rdata_o           = {num_banks_p{dma_rdata_i}};
    dma_rdata_ready_and_o  = reset_n_i & ~fifo_empty & bank_rdata_ready_and_i[head];
    if (in_pkt & any_elig) bank_pkt_ready_and_o[winner] = dma_pkt_ready_and_i;
    if (in_wdata) bank_wdata_ready_and_o[wbank_q] = dma_wdata_ready_and_i;
    if (reset_n_i & ~fifo_empty) bank_rdata_v_o[head] = dma_rdata_v_i;
  end

  assign pkt_hs = dma_pkt_v_o & dma_pkt_ready_and_i;
  assign wd_hs  = dma_wdata_v_o & dma_wdata_ready_and_i;
  assign rd_hs  = dma_rdata_v_i & dma_rdata_ready_and_o;
  assign push   = pkt_hs & ~win_is_write;
  assign pop    = rd_hs & (rcnt_q == last_beat_lp);

  // Packet / write-data FSM next state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_PKT: begin
        if (pkt_hs) begin
          rr_d = (winner == last_bank_lp) ? '0 : winner + id_w_lp'(1);
          if (win_is_write) begin
            wbank_d = winner;
            wcnt_d  = '0;
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (wd_hs) begin
          if (wcnt_q == last_beat_lp) begin
            wcnt_d  = '0;
            state_d = S_PKT;
          end else begin
            wcnt_d = wcnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: state_d = S_PKT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_PKT;
      rr_q    <= '0;
      wbank_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Read-order FIFO and read beat counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < rd_fifo_els_p; i++) fifo_mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      rcnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wptr_q] <= winner;
        wptr_q <= (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + occ_w_lp'(1);
        2'b01:   occ_q <= occ_q - occ_w_lp'(1);
        default: occ_q <= occ_q;
      endcase
      if (rd_hs) begin
        rcnt_q <= (rcnt_q == last_beat_lp) ? '0 : rcnt_q + cnt_w_lp'(1);
      end
    end
  end

`ifdef BP_DMA_ARB_PERF_EN
  logic [31:0] grant_cnt_q [num_banks_p];
  logic [31:0] stall_cnt_q;
  logic        rd_blocked;

  assign rd_blocked = fifo_full & (|(bank_pkt_v_i & ~is_write));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_banks_p; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < num_banks_p; i++) begin
        if (pkt_hs && (winner == id_w_lp'(i)) && (grant_cnt_q[i] != '1)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
      end
      if (rd_blocked && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    perf_grant_cnt_o = '0;
    for (int i = 0; i < num_banks_p; i++) perf_grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
  end
  assign perf_rd_full_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bp_dma_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_dma_bank_arbiter: directed self-checking bench for bp_dma_bank_arbiter
// with default parameters (2 banks, 40-bit packets, 64-bit data, 8-beat
// bursts, 4-deep read order FIFO). Inputs change 1 time unit after the rising
// edge; outputs are checked 1 time unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_bp_dma_bank_arbiter;

  localparam int N  = 2;
  localparam int PW = 40;
  localparam int DW = 64;
  localparam int BL = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [N*PW-1:0] bank_pkt;
  logic [N-1:0]    bank_pkt_v;
  logic [N-1:0]    bank_pkt_ready;
  logic [N*DW-1:0] bank_wdata;
  logic [N-1:0]    bank_wdata_v;
  logic [N-1:0]    bank_wdata_ready;
  logic [N*DW-1:0] bank_rdata;
  logic [N-1:0]    bank_rdata_v;
  logic [N-1:0]    bank_rdata_ready;
  logic [PW-1:0]   dma_pkt;
  logic            dma_pkt_v;
  logic            dma_pkt_ready;
  logic [DW-1:0]   dma_wdata;
  logic            dma_wdata_v;
  logic            dma_wdata_ready;
  logic [DW-1:0]   dma_rdata;
  logic            dma_rdata_v;
  logic            dma_rdata_ready;

  bp_dma_bank_arbiter #(
    .num_banks_p(N), .pkt_width_p(PW), .data_width_p(DW),
    .burst_len_p(BL), .rd_fifo_els_p(4)
  ) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .bank_pkt_i            (bank_pkt),
    .bank_pkt_v_i          (bank_pkt_v),
    .bank_pkt_ready_and_o  (bank_pkt_ready),
    .bank_wdata_i          (bank_wdata),
    .bank_wdata_v_i        (bank_wdata_v),
    .bank_wdata_ready_and_o(bank_wdata_ready),
    .bank_rdata_o          (bank_rdata),
    .bank_rdata_v_o        (bank_rdata_v),
    .bank_rdata_ready_and_i(bank_rdata_ready),
    .dma_pkt_o             (dma_pkt),
    .dma_pkt_v_o           (dma_pkt_v),
    .dma_pkt_ready_and_i   (dma_pkt_ready),
    .dma_wdata_o           (dma_wdata),
    .dma_wdata_v_o         (dma_wdata_v),
    .dma_wdata_ready_and_i (dma_wdata_ready),
    .dma_rdata_i           (dma_rdata),
    .dma_rdata_v_i         (dma_rdata_v),
    .dma_rdata_ready_and_o (dma_rdata_ready)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic w, input logic [PW-2:0] addr);
    return {w, addr};
  endfunction

  // One full 8-beat read burst expected at bank 'bank'; data base+k.
  task automatic rd_burst(input int bank, input int base);
    logic [N-1:0] exp_v;
    exp_v = '0;
    exp_v[bank] = 1'b1;
    for (int k = 0; k < BL; k++) begin
      dma_rdata   = DW'(base + k);
      dma_rdata_v = 1'b1;
      settle();
      chk("rd_ret_v", 64'(bank_rdata_v), 64'(exp_v));
      chk("rd_ret_rdy", 64'(dma_rdata_ready), 64'd1);
      chk("rd_ret_data", bank_rdata[bank*DW +: DW], 64'(base + k));
      step();
    end
    dma_rdata_v = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [N-1:0] ev;
    reset_n          = 1'b0;
    bank_pkt         = '0;
    bank_pkt_v       = '0;
    bank_wdata       = '0;
    bank_wdata_v     = '0;
    bank_rdata_ready = 2'b11;
    dma_pkt_ready    = 1'b0;
    dma_wdata_ready  = 1'b0;
    dma_rdata        = '0;
    dma_rdata_v      = 1'b0;

    // Reset state: valids/readies low even with requests present.
    bank_pkt_v    = 2'b11;
    dma_pkt_ready = 1'b1;
    dma_rdata_v   = 1'b1;
    #2;
    chk("rst_pkt_v", 64'(dma_pkt_v), 64'd0);
    chk("rst_pkt_rdy", 64'(bank_pkt_ready), 64'd0);
    chk("rst_wdata_v", 64'(dma_wdata_v), 64'd0);
    chk("rst_rdata_rdy", 64'(dma_rdata_ready), 64'd0);
    chk("rst_rdata_v", 64'(bank_rdata_v), 64'd0);
    bank_pkt_v  = 2'b00;
    dma_rdata_v = 1'b0;
    #10 reset_n = 1'b1;
    step();

    // ---- Read arbitration: both banks request reads continuously ----
    bank_pkt[0*PW +: PW] = mk_pkt(1'b0, 39'h100);
    bank_pkt[1*PW +: PW] = mk_pkt(1'b0, 39'h200);
    bank_pkt_v = 2'b11;
    for (int g = 0; g < 4; g++) begin
      settle();
      ev = (g % 2 == 0) ? 2'b01 : 2'b10;
      chk("arb_rdy", 64'(bank_pkt_ready), 64'(ev));
      chk("arb_pkt_v", 64'(dma_pkt_v), 64'd1);
      chk("arb_pkt", 64'(dma_pkt), (g % 2 == 0) ? 64'h100 : 64'h200);
      step();
    end
    settle();
    chk("full_no_5th_v", 64'(dma_pkt_v), 64'd0);
    chk("full_no_5th_rdy", 64'(bank_pkt_ready), 64'd0);

    // ---- Drain [0,1,0,1] with a same-cycle pop/request, then backpressure ----
    bank_pkt_v = 2'b01;
    for (int b = 0; b < 40; b++) begin
      if (b == 9) bank_pkt_v = 2'b00;
      dma_rdata   = DW'(b);
      dma_rdata_v = 1'b1;
      ev = ((b / 8) % 2 == 0) ? 2'b01 : 2'b10;
      if (b == 12) begin
        // Head is bank 1: hold it off for 3 cycles.
        bank_rdata_ready = 2'b01;
        for (int s = 0; s < 3; s++) begin
          settle();
          chk("bp_rdy", 64'(dma_rdata_ready), 64'd0);
          chk("bp_v", 64'(bank_rdata_v), 64'(ev));
          step();
        end
        bank_rdata_ready = 2'b11;
      end
      settle();
      chk("drain_v", 64'(bank_rdata_v), 64'(ev));
      chk("drain_rdy", 64'(dma_rdata_ready), 64'd1);
      chk("drain_data", bank_rdata[DW +: DW], 64'(b));
      if (b <= 7) chk("full_pop_no_grant", 64'(dma_pkt_v), 64'd0);
      if (b == 8) begin
        chk("full_grant_next_v", 64'(dma_pkt_v), 64'd1);
        chk("full_grant_next_rdy", 64'(bank_pkt_ready), 64'd1);
      end
      step();
    end
    settle();
    chk("empty_rdy", 64'(dma_rdata_ready), 64'd0);
    chk("empty_v", 64'(bank_rdata_v), 64'd0);
    dma_rdata_v = 1'b0;

    // ---- Write burst: bank 1 write (rr=1), bank 0 read pending ----
    bank_pkt[0*PW +: PW] = mk_pkt(1'b0, 39'h400);
    bank_pkt[1*PW +: PW] = mk_pkt(1'b1, 39'h300);
    bank_pkt_v      = 2'b11;
    bank_wdata_v    = 2'b10;
    bank_wdata[DW +: DW] = 64'h10;
    dma_wdata_ready = 1'b1;
    settle();
    chk("wr_grant_rdy", 64'(bank_pkt_ready), 64'b10);
    chk("wr_grant_pkt", 64'(dma_pkt), 64'h80_0000_0300);
    chk("wr_pre_wv", 64'(dma_wdata_v), 64'd0);
    chk("wr_pre_wrdy", 64'(bank_wdata_ready), 64'd0);
    step();
    for (int k = 0; k < BL; k++) begin
      bank_wdata[DW +: DW] = 64'(16 + k);
      if (k == 3) begin
        dma_wdata_ready = 1'b0;
        settle();
        chk("wr_stall_rdy", 64'(bank_wdata_ready), 64'd0);
        chk("wr_stall_v", 64'(dma_wdata_v), 64'd1);
        step();
        dma_wdata_ready = 1'b1;
      end
      settle();
      chk("wr_data", dma_wdata, 64'(16 + k));
      chk("wr_v", 64'(dma_wdata_v), 64'd1);
      chk("wr_rdy", 64'(bank_wdata_ready), 64'b10);
      chk("wr_pkt_blocked", 64'(dma_pkt_v), 64'd0);
      chk("wr_pkt_rdy0", 64'(bank_pkt_ready), 64'd0);
      step();
    end
    bank_wdata_v = 2'b00;
    settle();
    chk("post_wr_v", 64'(dma_pkt_v), 64'd1);
    chk("post_wr_rdy", 64'(bank_pkt_ready), 64'b01);
    chk("post_wr_pkt", 64'(dma_pkt), 64'h400);
    chk("post_wr_wv", 64'(dma_wdata_v), 64'd0);
    step();
    bank_pkt_v = 2'b00;

    // ---- Read return order: FIFO [0] then reads from 1,0,1 ----
    bank_pkt[1*PW +: PW] = mk_pkt(1'b0, 39'h500);
    for (int g = 0; g < 3; g++) begin
      ev = (g % 2 == 0) ? 2'b10 : 2'b01;
      bank_pkt_v = ev;
      settle();
      chk("ord_grant", 64'(bank_pkt_ready), 64'(ev));
      step();
    end
    bank_pkt_v = 2'b00;
    rd_burst(0, 'h40);
    rd_burst(1, 'h50);
    rd_burst(0, 'h60);
    rd_burst(1, 'h70);
    settle();
    chk("ord_empty", 64'(dma_rdata_ready), 64'd0);

    // ---- Reset mid-burst (rr=0 here) ----
    bank_pkt_v = 2'b10;                       // read from bank 1 -> FIFO [1], rr=0
    settle();
    chk("rm_rd_grant", 64'(bank_pkt_ready), 64'b10);
    step();
    bank_pkt[0*PW +: PW] = mk_pkt(1'b1, 39'h600);
    bank_pkt_v = 2'b01;                       // write from bank 0 -> rr=1
    settle();
    chk("rm_wr_grant", 64'(bank_pkt_ready), 64'b01);
    step();
    bank_pkt_v   = 2'b00;
    bank_wdata_v = 2'b01;
    for (int k = 0; k < 3; k++) begin
      bank_wdata[0 +: DW] = 64'(32 + k);
      settle();
      chk("rm_wdata", dma_wdata, 64'(32 + k));
      step();
    end
    bank_wdata[0 +: DW] = 64'd35;
    settle();
    chk("rm_beat3_v", 64'(dma_wdata_v), 64'd1);
    chk("rm_pre_rrdy", 64'(dma_rdata_ready), 64'd1);
    bank_pkt[0*PW +: PW] = mk_pkt(1'b0, 39'h700);
    bank_pkt[1*PW +: PW] = mk_pkt(1'b0, 39'h800);
    bank_pkt_v = 2'b11;
    #2 reset_n = 1'b0;
    dma_rdata_v = 1'b1;
    #1;
    chk("rm_async_wv", 64'(dma_wdata_v), 64'd0);
    chk("rm_async_wrdy", 64'(bank_wdata_ready), 64'd0);
    chk("rm_async_pv", 64'(dma_pkt_v), 64'd0);
    chk("rm_async_prdy", 64'(bank_pkt_ready), 64'd0);
    chk("rm_async_rrdy", 64'(dma_rdata_ready), 64'd0);
    chk("rm_async_rv", 64'(bank_rdata_v), 64'd0);
    step();
    #3 reset_n = 1'b1;
    bank_wdata_v = 2'b00;
    #1;
    chk("rm_post_fifo_empty", 64'(dma_rdata_ready), 64'd0);
    chk("rm_post_rv", 64'(bank_rdata_v), 64'd0);
    chk("rm_post_wv", 64'(dma_wdata_v), 64'd0);
    chk("rm_post_pv", 64'(dma_pkt_v), 64'd1);
    chk("rm_post_grant0", 64'(bank_pkt_ready), 64'b01);
    chk("rm_post_pkt", 64'(dma_pkt), 64'h700);
    step();
    bank_pkt_v = 2'b00;
    settle();
    chk("rm_new_head_v", 64'(bank_rdata_v), 64'b01);
    chk("rm_new_rrdy", 64'(dma_rdata_ready), 64'd1);
    dma_rdata_v = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_dma_bank_arbiter.md
Name: bp_dma_bank_arbiter

Overview:
- Shares one DRAM DMA channel among `num_banks_p` L2 bank DMA ports of the unicore.
- Forwards packets using round-robin arbitration, with one grant per packet handshake.
- Routes each write-data burst from the granted bank to DRAM.
- Returns read-data bursts to requesting banks in issue order, tracked by an order FIFO.
- Sits between the per-bank `dma_pkt`/`dma_data` ports and the single off-chip DMA link.

Parameters:
- `num_banks_p`, 2: number of L2 bank DMA ports (>=2).
- `pkt_width_p`, 40: DMA packet width. Bit `pkt_width_p-1` is `write_not_read`.
- `data_width_p`, 64: DMA data beat width (the L2 fill width).
- `burst_len_p`, 8: data beats per DMA packet (block size / fill width). Must be >=1.
- `rd_fifo_els_p`, 4: maximum outstanding read packets (order FIFO depth, >=2).

Ports:
- `clk_i` input 1: clock.
- `reset_n_i` input 1: reset, asynchronous, active-low.
- `bank_pkt_i` input `num_banks_p*pkt_width_p`: per-bank DMA packet.
- `bank_pkt_v_i` input `num_banks_p`: per-bank packet valid.
- `bank_pkt_ready_and_o` output `num_banks_p`: per-bank packet ready.
- `bank_wdata_i` input `num_banks_p*data_width_p`: per-bank write data.
- `bank_wdata_v_i` input `num_banks_p`: write data valid.
- `bank_wdata_ready_and_o` output `num_banks_p`: write data ready.
- `bank_rdata_o` output `num_banks_p*data_width_p`: read data to banks, broadcast.
- `bank_rdata_v_o` output `num_banks_p`: read data valid, one-hot.
- `bank_rdata_ready_and_i` input `num_banks_p`: bank read-data ready.
- `dma_pkt_o` output `pkt_width_p`: packet to DRAM.
- `dma_pkt_v_o` output 1: packet valid.
- `dma_pkt_ready_and_i` input 1: DRAM packet ready.
- `dma_wdata_o` output `data_width_p`: write data to DRAM.
- `dma_wdata_v_o` output 1: write data valid.
- `dma_wdata_ready_and_i` input 1: DRAM write-data ready.
- `dma_rdata_i` input `data_width_p`: read data from DRAM.
- `dma_rdata_v_i` input 1: read data valid.
- `dma_rdata_ready_and_o` output 1: read data ready.

Behaviour:
- **Handshakes.** All ports are valid/ready-and. A transfer occurs on a cycle where both valid and ready are high. Valid never depends on ready; ready may depend on valid.
- **Reset.** Reset is asynchronous, active-low. While it is asserted:
  - FSM is in `S_PKT`.
  - Round-robin pointer is 0.
  - Order FIFO is empty.
  - Write and read beat counters are 0.
  - All `*_v_o` and `*_ready_and_o` outputs are 0.
  - Data outputs are don't-care.
  - Reset mid-burst discards all in-flight state; there is no recovery.
- **Eligibility.** Bank i is eligible when `bank_pkt_v_i[i]` is high, and additionally, for reads (`write_not_read`=0), the order FIFO is not full.
- **`S_PKT`.**
  - Winner = first eligible bank at or after the RR pointer, wrapping modulo `num_banks_p`.
  - `dma_pkt_o` = winner's packet; `dma_pkt_v_o` = any eligible.
  - `bank_pkt_ready_and_o[winner]` = `dma_pkt_ready_and_i`; all others are 0.
  - The path is combinational, zero latency.
  - The winner may change while `dma_pkt_v_o` is held but not accepted.
- **On packet handshake.**
  - RR pointer becomes winner+1, mod `num_banks_p`.
  - If read: push winner id into the order FIFO; stay in `S_PKT`.
  - If write: latch `wbank` = winner, clear the write counter, go to `S_WDATA`.
- **`S_WDATA`.**
  - `dma_pkt_v_o` = 0; all `bank_pkt_ready_and_o` = 0.
  - `dma_wdata_o`/`dma_wdata_v_o` pass from `wbank`.
  - `bank_wdata_ready_and_o[wbank]` = `dma_wdata_ready_and_i`; all other banks read 0.
  - Each write-data handshake increments the counter.
  - The handshake with counter == `burst_len_p-1` clears the counter and returns to `S_PKT` on the next cycle.
- **Outside `S_WDATA`.** `dma_wdata_v_o` = 0 and all `bank_wdata_ready_and_o` = 0.
- **Read return.** Runs concurrently with and independent of the FSM.
  - Head = FIFO head bank id.
  - `bank_rdata_o` = `dma_rdata_i` for every bank.
  - `bank_rdata_v_o[head]` = `dma_rdata_v_i` when the FIFO is non-empty; all other bits are 0.
  - `dma_rdata_ready_and_o` = FIFO non-empty AND `bank_rdata_ready_and_i[head]`.
  - Each read-data handshake increments the read counter.
  - The handshake at `burst_len_p-1` pops the FIFO and clears the counter.
- **FIFO push and pop in the same cycle.** Both take effect and the occupancy is unchanged. When full, a same-cycle pop does not make reads eligible; eligibility uses registered fullness.
- **FIFO empty.** `dma_rdata_ready_and_o` = 0; unsolicited DRAM data stalls.
- **`burst_len_p`=1.** `S_WDATA` lasts exactly one handshake, and each read beat pops the FIFO.
- **Counter width** is `$clog2(burst_len_p)` with a minimum of 1 bit. Counters do not wrap; they clear at the last beat.

Optional Feature:
- Macro: `BP_DMA_ARB_PERF_EN`.
- **When defined**, the block adds two output ports:
  - `perf_grant_cnt_o` (`num_banks_p*32`): per-bank packet-grant counters.
  - `perf_rd_full_stall_o` (32): count of cycles in which some read request was valid but blocked by a full order FIFO.
  - Both counters reset to 0 and saturate at `2^32-1`.
- **When undefined**, these ports and their logic are absent. Functional behaviour is identical either way.

Test Plan:
- **Read arbitration.** Banks 0 and 1 both present reads continuously with `dma_pkt_ready_and_i`=1. Required: grants alternate 0,1,0,1; the FIFO holds [0,1,0,1]; with `rd_fifo_els_p`=4, no fifth grant occurs until a pop.
- **Write burst.** Bank 1 sends a write with 8 data beats 0x10..0x17, while bank 0 holds a read. Required: `dma_wdata_o` shows 0x10..0x17 in order; bank 0's packet is not granted until the cycle after the 8th beat; then bank 0 is granted.
- **Read return order.** Issue reads from banks 1, 0, 1, then return 24 beats. Required: beats 0-7 go to bank 1, beats 8-15 to bank 0, and beats 16-23 to bank 1, each with one-hot `bank_rdata_v_o`.
- **Backpressure.** Deassert `bank_rdata_ready_and_i[head]` for 3 cycles mid-burst. Required: `dma_rdata_ready_and_o`=0 for those 3 cycles; no beat is lost or duplicated; the counter resumes correctly.
- **Full FIFO.** With the FIFO full and a pop and a new read request in the same cycle, required: no read grant that cycle; the grant occurs the following cycle.
- **Reset mid-burst.** Assert `reset_n_i`=0 at write beat 3 of 8. Required: all valid and ready outputs go to 0 immediately (asynchronously); after release, the FSM is in `S_PKT` with an empty FIFO and the next grant goes to bank 0.
